// File: rtl/serial_sub_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The requester drives start/a/b; the subtractor returns busy/done/diff/bout.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_bout;

    modport master (
        output i_start, i_a, i_b,
        input  o_busy, o_done, o_diff, o_bout
    );

    modport slave (
        input  i_start, i_a, i_b,
        output o_busy, o_done, o_diff, o_bout
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell with a registered borrow.
// The operands are consumed LSB-first, and the difference is shifted in from the MSB side.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;
    logic             r_bout;

    logic             w_d;
    logic             w_bnew;
    logic             w_last;
    logic [WIDTH-1:0] w_diff_nxt;

    assign w_d    = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_bnew = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // The result register doubles as the output, so the new bit enters at the MSB.
    always_comb begin
        w_diff_nxt            = r_diff >> 1;
        w_diff_nxt[WIDTH-1]   = w_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_bout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_a      <= bus.i_a;
                        r_b      <= bus.i_b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_diff   <= w_diff_nxt;
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_bnew;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_bout  <= w_bnew;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_diff = r_diff;
    assign bus.o_bout = r_bout;
endmodule
